// File: rtl/cnn_layer_accel_weight_table_loader.sv
// Write-side sequencer for the CE weight table: streams 3x3 kernel weights into the table,
// zero-padding each kernel out to C_KRNL_SLOTS writes, and brackets the load with config_mode/config_done.
module cnn_layer_accel_weight_table_loader #(
  parameter int unsigned C_WEIGHT_WIDTH     = 16,
  parameter int unsigned C_KRNL_WHTS        = 9,
  parameter int unsigned C_KRNL_SLOTS       = 16,
  parameter int unsigned C_CLG2_MAX_KERNELS = 6
) (
  input  logic                          clk_core,
  input  logic                          rst,
  input  logic                          job_start,
  input  logic [C_CLG2_MAX_KERNELS-1:0] num_kernels,
  input  logic                          wht_in_valid,
  input  logic [C_WEIGHT_WIDTH-1:0]     wht_in_data,
  output logic                          wht_in_ready,
  output logic                          config_mode,
  output logic                          wht_config_wren,
  output logic [C_WEIGHT_WIDTH-1:0]     wht_config_data,
  output logic                          config_done,
  output logic                          busy
);

  localparam int unsigned SLOT_W = $clog2(C_KRNL_SLOTS);
  localparam int unsigned KRN_W  = C_CLG2_MAX_KERNELS;

  localparam logic [SLOT_W-1:0] LAST_WHT  = SLOT_W'(C_KRNL_WHTS - 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(C_KRNL_SLOTS - 1);
  localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);
  localparam logic [KRN_W-1:0]  KRN_ONE   = KRN_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_PAD,
    S_DONE
  } state_e;

  state_e                    state_q,  state_d;
  logic [SLOT_W-1:0]         slot_q,   slot_d;
  logic [KRN_W-1:0]          kernel_q, kernel_d;
  logic [KRN_W-1:0]          last_k_q, last_k_d;
  logic                      mode_q,   mode_d;
  logic                      wren_q,   wren_d;
  logic [C_WEIGHT_WIDTH-1:0] wdata_q,  wdata_d;
  logic                      done_q,   done_d;
  logic                      handshake;

  assign wht_in_ready    = (state_q == S_LOAD);
  assign busy            = (state_q != S_IDLE);
  assign handshake       = wht_in_ready && wht_in_valid;
  assign config_mode     = mode_q;
  assign wht_config_wren = wren_q;
  assign wht_config_data = wdata_q;
  assign config_done     = done_q;

  // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    kernel_d = kernel_q;
    last_k_d = last_k_q;
    mode_d   = mode_q;
    wren_d   = 1'b0;
    wdata_d  = '0;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: ;
      S_LOAD: begin
        if (handshake) begin
          wren_d  = 1'b1;
          wdata_d = wht_in_data;
          slot_d  = slot_q + SLOT_ONE;
          if (slot_q == LAST_WHT) state_d = S_PAD;
        end
      end
      S_PAD: begin
        wren_d = 1'b1;
        if (slot_q == LAST_SLOT) begin
          slot_d = '0;
          if (kernel_q == last_k_q) begin
            state_d = S_DONE;
          end else begin
            kernel_d = kernel_q + KRN_ONE;
            state_d  = S_LOAD;
          end
        end else begin
          slot_d = slot_q + SLOT_ONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        mode_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A new job overrides everything except the done pulse of a job that just completed.
    // A weight handshaken in this same cycle belongs to the abandoned job and is dropped.
    if (job_start) begin
      state_d  = S_LOAD;
      slot_d   = '0;
      kernel_d = '0;
      last_k_d = num_kernels;
      mode_d   = 1'b1;
      wren_d   = 1'b0;
      wdata_d  = '0;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' only; the async reset clears every register immediately.
  always_ff @(posedge clk_core or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      slot_q   <= '0;
      kernel_q <= '0;
      last_k_q <= '0;
      mode_q   <= 1'b0;
      wren_q   <= 1'b0;
      wdata_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      kernel_q <= kernel_d;
      last_k_q <= last_k_d;
      mode_q   <= mode_d;
      wren_q   <= wren_d;
      wdata_q  <= wdata_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_cnn_layer_accel_weight_table_loader.sv
// Directed bench for the weight table loader: table writes and done pulses are captured on the
// falling edge and compared against expected streams built from the stimulus.
module tb_cnn_layer_accel_weight_table_loader;

  logic        clk_core = 1'b0;
  logic        rst = 1'b1;
  logic        job_start = 1'b0;
  logic [5:0]  num_kernels = '0;
  logic        wht_in_valid = 1'b0;
  logic [15:0] wht_in_data = '0;
  logic        wht_in_ready;
  logic        config_mode;
  logic        wht_config_wren;
  logic [15:0] wht_config_data;
  logic        config_done;
  logic        busy;

  cnn_layer_accel_weight_table_loader dut (
    .clk_core        (clk_core),
    .rst             (rst),
    .job_start       (job_start),
    .num_kernels     (num_kernels),
    .wht_in_valid    (wht_in_valid),
    .wht_in_data     (wht_in_data),
    .wht_in_ready    (wht_in_ready),
    .config_mode     (config_mode),
    .wht_config_wren (wht_config_wren),
    .wht_config_data (wht_config_data),
    .config_done     (config_done),
    .busy            (busy)
  );

  always #5 clk_core = ~clk_core;

  int compared   = 0;
  int mismatched = 0;
  int edge_cnt   = 0;
  int bad_mode   = 0;
  int done_mode  = 0;
  int err_ready  = 0;
  int last_e0    = 0;
  logic [15:0] wr_data_q[$];
  int          wr_edge_q[$];
  int          done_edge_q[$];
  logic [15:0] exp_q[$];

  always @(posedge clk_core) edge_cnt++;

  always @(negedge clk_core) begin
    if (!rst) begin
      if (wht_config_wren) begin
        wr_data_q.push_back(wht_config_data);
        wr_edge_q.push_back(edge_cnt);
        if (!config_mode) bad_mode++;
      end
      if (config_done) begin
        done_edge_q.push_back(edge_cnt);
        if (config_mode) done_mode++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic clear_state();
    wr_data_q.delete();
    wr_edge_q.delete();
    done_edge_q.delete();
    exp_q.delete();
    bad_mode  = 0;
    done_mode = 0;
    err_ready = 0;
  endtask

  // Expected table contents for a full job: 9 stream words then 7 zeros per kernel.
  task automatic append_expected(input int nk, input int base);
    for (int k = 0; k <= nk; k++) begin
      for (int j = 0; j < 9; j++) exp_q.push_back(16'(base + 9 * k + j));
      for (int j = 0; j < 7; j++) exp_q.push_back(16'h0000);
    end
  endtask

  function automatic int count_diffs();
    int d = 0;
    if (wr_data_q.size() != exp_q.size()) d++;
    for (int i = 0; i < wr_data_q.size() && i < exp_q.size(); i++)
      if (wr_data_q[i] !== exp_q[i]) d++;
    return d;
  endfunction

  function automatic bit done_after(input int e);
    return (done_edge_q.size() != 0) && (done_edge_q[done_edge_q.size() - 1] > e);
  endfunction

  // Pulses job_start at edge+1 and feeds the stream base+idx until done, abort_at handshakes, or budget.
  task automatic run_job(input int nk, input int base, input bit toggle, input int abort_at);
    int idx = 0, cycles = 0, hs_k = 0, pad_left = 0;
    int total  = 9 * (nk + 1);
    int budget = 4 * (nk + 1) * 16 + 64;
    job_start    = 1'b1;
    num_kernels  = nk[5:0];
    wht_in_valid = 1'b0;
    @(posedge clk_core); #1;
    job_start = 1'b0;
    last_e0   = edge_cnt;
    while (!done_after(last_e0) && idx != abort_at && cycles < budget) begin
      wht_in_valid = toggle ? ((cycles % 2) == 0) : 1'b1;
      wht_in_data  = 16'(base + idx);
      if (pad_left > 0) begin
        if (wht_in_ready !== 1'b0) err_ready++;
        pad_left--;
      end else if (idx >= total && wht_in_ready !== 1'b0) begin
        err_ready++;
      end
      if (wht_in_valid && wht_in_ready) begin
        idx++;
        hs_k++;
        if (hs_k == 9) begin
          hs_k     = 0;
          pad_left = 7;
        end
      end
      @(posedge clk_core); #1;
      cycles++;
    end
    wht_in_valid = 1'b0;
    if (cycles >= budget) begin
      compared++; mismatched++;
      $display("FAIL run_job_timeout: nk=%0d no config_done within %0d cycles", nk, budget);
    end
  endtask

  task automatic test_reset();
    #12;
    compared++;
    if ({wht_in_ready, config_mode, wht_config_wren, config_done, busy, wht_config_data} !== 21'd0) begin
      mismatched++;
      $display("FAIL reset_outputs: got ready=%b mode=%b wren=%b done=%b busy=%b data=%h, required all 0",
               wht_in_ready, config_mode, wht_config_wren, config_done, busy, wht_config_data);
    end
    @(negedge clk_core); rst = 1'b0;
    @(posedge clk_core); #1;
  endtask

  task automatic test_single_kernel();
    int bad_edges = 0;
    clear_state();
    append_expected(0, 1);
    run_job(0, 1, 1'b0, -1);
    repeat (3) @(posedge clk_core); #1;
    compared++;
    if (count_diffs() !== 0) begin
      mismatched++;
      $display("FAIL single_data: %0d writes/%0d diffs, required 16 writes 1..9 then 0s", wr_data_q.size(), count_diffs());
    end
    for (int i = 0; i < wr_edge_q.size(); i++) if (wr_edge_q[i] != last_e0 + 1 + i) bad_edges++;
    compared++;
    if (bad_edges !== 0) begin
      mismatched++;
      $display("FAIL single_write_timing: %0d writes off their cycle, required one per cycle from job+1", bad_edges);
    end
    compared++;
    if (done_edge_q.size() !== 1 || done_edge_q[0] - last_e0 !== 17) begin
      mismatched++;
      $display("FAIL single_done: count=%0d delay=%0d, required 1 pulse 17 cycles after job_start edge",
               done_edge_q.size(), (done_edge_q.size() != 0) ? done_edge_q[0] - last_e0 : -1);
    end
    compared++;
    if (bad_mode !== 0 || done_mode !== 0) begin
      mismatched++;
      $display("FAIL single_mode: wren without mode=%0d, mode high at done=%0d, required 0/0", bad_mode, done_mode);
    end
    compared++;
    if (err_ready !== 0 || config_mode !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL single_ready_end: ready errors=%0d mode=%b busy=%b, required 0/0/0", err_ready, config_mode, busy);
    end
  endtask

  task automatic test_toggle_valid();
    clear_state();
    append_expected(2, 50);
    run_job(2, 50, 1'b1, -1);
    repeat (3) @(posedge clk_core); #1;
    compared++;
    if (count_diffs() !== 0) begin
      mismatched++;
      $display("FAIL toggle_data: %0d writes/%0d diffs, required 48 writes", wr_data_q.size(), count_diffs());
    end
    compared++;
    if (err_ready !== 0) begin
      mismatched++;
      $display("FAIL toggle_pad_ready: %0d cycles with ready=1 in PAD/after load, required 0", err_ready);
    end
    compared++;
    if (done_edge_q.size() !== 1 || bad_mode !== 0) begin
      mismatched++;
      $display("FAIL toggle_done: done pulses=%0d wren without mode=%0d, required 1/0", done_edge_q.size(), bad_mode);
    end
  endtask

  task automatic test_abort_restart();
    clear_state();
    for (int j = 0; j < 9; j++) exp_q.push_back(16'(100 + j));
    for (int j = 0; j < 7; j++) exp_q.push_back(16'h0000);
    for (int j = 9; j < 13; j++) exp_q.push_back(16'(100 + j));
    append_expected(1, 200);
    run_job(3, 100, 1'b0, 13);
    compared++;
    if (done_edge_q.size() !== 0) begin
      mismatched++;
      $display("FAIL abort_no_done: %0d done pulses before restart, required 0", done_edge_q.size());
    end
    run_job(1, 200, 1'b0, -1);
    repeat (3) @(posedge clk_core); #1;
    compared++;
    if (count_diffs() !== 0) begin
      mismatched++;
      $display("FAIL abort_data: %0d writes/%0d diffs, required 20 aborted + 32 new", wr_data_q.size(), count_diffs());
    end
    compared++;
    if (done_edge_q.size() !== 1) begin
      mismatched++;
      $display("FAIL abort_done_count: %0d done pulses, required 1", done_edge_q.size());
    end
  endtask

  task automatic test_async_reset();
    int ready_hi = 0;
    clear_state();
    run_job(1, 300, 1'b0, 5);
    #2 rst = 1'b1;
    #1;
    compared++;
    if ({wht_in_ready, config_mode, wht_config_wren, config_done, busy, wht_config_data} !== 21'd0) begin
      mismatched++;
      $display("FAIL async_reset_outputs: ready=%b mode=%b wren=%b done=%b busy=%b data=%h, required all 0",
               wht_in_ready, config_mode, wht_config_wren, config_done, busy, wht_config_data);
    end
    @(negedge clk_core); rst = 1'b0;
    wr_data_q.delete();
    wr_edge_q.delete();
    @(posedge clk_core); #1;
    repeat (6) begin
      wht_in_valid = 1'b1;
      wht_in_data  = 16'h1234;
      if (wht_in_ready !== 1'b0) ready_hi++;
      @(posedge clk_core); #1;
    end
    wht_in_valid = 1'b0;
    compared++;
    if (ready_hi !== 0 || wr_data_q.size() !== 0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL post_reset_idle: ready cycles=%0d writes=%0d busy=%b, required 0/0/0", ready_hi, wr_data_q.size(), busy);
    end
    append_expected(0, 400);
    run_job(0, 400, 1'b0, -1);
    repeat (3) @(posedge clk_core); #1;
    compared++;
    if (count_diffs() !== 0 || done_edge_q.size() !== 1) begin
      mismatched++;
      $display("FAIL post_reset_load: %0d writes/%0d diffs, done=%0d, required 16 writes, 1 done",
               wr_data_q.size(), count_diffs(), done_edge_q.size());
    end
  endtask

  task automatic test_max_kernels();
    clear_state();
    append_expected(63, 1000);
    run_job(63, 1000, 1'b0, -1);
    repeat (3) @(posedge clk_core); #1;
    compared++;
    if (count_diffs() !== 0) begin
      mismatched++;
      $display("FAIL max_kernels_data: %0d writes/%0d diffs, required 1024 writes", wr_data_q.size(), count_diffs());
    end
    compared++;
    if (done_edge_q.size() !== 1 || bad_mode !== 0 || err_ready !== 0) begin
      mismatched++;
      $display("FAIL max_kernels_done: done=%0d wren without mode=%0d ready errors=%0d, required 1/0/0",
               done_edge_q.size(), bad_mode, err_ready);
    end
  endtask

  task automatic test_idle_pending();
    int ready_hi = 0;
    clear_state();
    repeat (6) begin
      wht_in_valid = 1'b1;
      wht_in_data  = 16'hBEEF;
      if (wht_in_ready !== 1'b0) ready_hi++;
      @(posedge clk_core); #1;
    end
    wht_in_valid = 1'b0;
    compared++;
    if (ready_hi !== 0 || wr_data_q.size() !== 0) begin
      mismatched++;
      $display("FAIL idle_pending: ready cycles=%0d writes=%0d, required 0/0", ready_hi, wr_data_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int idx = 0;
    int e0;
    clear_state();
    append_expected(0, 600);
    append_expected(0, 700);
    job_start   = 1'b1;
    num_kernels = 6'd0;
    @(posedge clk_core); #1;
    job_start = 1'b0;
    e0 = edge_cnt;
    repeat (16) begin
      wht_in_valid = 1'b1;
      wht_in_data  = 16'(600 + idx);
      if (wht_in_ready) idx++;
      @(posedge clk_core); #1;
    end
    wht_in_valid = 1'b1;
    wht_in_data  = 16'(600 + idx);
    compared++;
    if (wht_in_ready !== 1'b0 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL done_state_ready: ready=%b busy=%b in DONE, required 0/1", wht_in_ready, busy);
    end
    run_job(0, 700, 1'b0, -1);
    repeat (3) @(posedge clk_core); #1;
    compared++;
    if (count_diffs() !== 0) begin
      mismatched++;
      $display("FAIL b2b_data: %0d writes/%0d diffs, required 32 writes", wr_data_q.size(), count_diffs());
    end
    compared++;
    if (done_edge_q.size() !== 2 || done_edge_q[0] !== e0 + 17 || done_edge_q[0] !== last_e0) begin
      mismatched++;
      $display("FAIL b2b_done: pulses=%0d first at %0d, required 2 with first at %0d (restart edge)",
               done_edge_q.size(), (done_edge_q.size() != 0) ? done_edge_q[0] - e0 : -1, 17);
    end
  endtask

  initial begin
    test_reset();
    test_single_kernel();
    test_toggle_valid();
    test_abort_restart();
    test_async_reset();
    test_max_kernels();
    test_idle_pending();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
